flip_pipe: RTL

FLIP_PIPE -- requirements
Module: flip_pipe

---
 rtl/flip_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/flip_pipe.sv
// Othello-style flip engine: computes flipped discs, legality, popcount and post-move boards.
// Latency: 2 cycles (walk result registered in S1, count/next boards registered in S2).
// Backpressure: valid/ready; stages hold when blocked, in_ready falls only when both stages are full.
module flip_pipe #(
    parameter int N     = 8,
    parameter int CELLS = N * N,
    parameter int PW    = $clog2(CELLS)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CELLS-1:0]             player,
    input  logic [CELLS-1:0]             opponent,
    input  logic [PW-1:0]                pos,
    input  logic                         apply,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CELLS-1:0]             flip,
    output logic                         legal,
    output logic [$clog2(CELLS+1)-1:0]   count,
    output logic [CELLS-1:0]             next_player,
    output logic [CELLS-1:0]             next_opponent
);

    localparam int CW = $clog2(CELLS + 1);

    logic             v1, v2;
    logic             en1, en2;

    // Move-square one-hot; zero when pos is off the board, which also marks it out of range.
    logic [CELLS-1:0] pos_bit;
    logic             start_ok;

    logic [CELLS-1:0] walk_flip;
    logic [CELLS-1:0] run;
    logic             walking;
    logic             hit;
    int               r0, c0, rr, cc;
    logic [PW-1:0]    idx;

    logic [CELLS-1:0] s1_flip;
    logic [CELLS-1:0] s1_player;
    logic [CELLS-1:0] s1_opponent;
    logic [CELLS-1:0] s1_pos_bit;
    logic             s1_apply;

    logic             legal_c;
    logic [CW-1:0]    count_c;
    logic [CELLS-1:0] next_player_c;
    logic [CELLS-1:0] next_opponent_c;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    assign pos_bit  = {{(CELLS-1){1'b0}}, 1'b1} << pos;
    assign start_ok = (|pos_bit) && !(|((player | opponent) & pos_bit));

    // Walk all 8 directions from pos; a direction contributes its opponent run only if capped by a player disc.
    always_comb begin
        walk_flip = '0;
        run       = '0;
        walking   = 1'b0;
        hit       = 1'b0;
        rr        = 0;
        cc        = 0;
        idx       = '0;
        r0        = int'(pos) / N;
        c0        = int'(pos) % N;
        for (int d = 0; d < 9; d++) begin
            run     = '0;
            walking = (d != 4);
            hit     = 1'b0;
            for (int k = 1; k < N; k++) begin
                rr  = r0 + k * (d / 3 - 1);
                cc  = c0 + k * (d % 3 - 1);
                idx = PW'(rr * N + cc);
                if (walking) begin
                    if (rr < 0 || rr >= N || cc < 0 || cc >= N) begin
                        walking = 1'b0;
                    end else if (opponent[idx]) begin
                        run[idx] = 1'b1;
                    end else begin
                        walking = 1'b0;
                        hit     = player[idx];
                    end
                end
            end
            if (hit && start_ok) begin
                walk_flip = walk_flip | run;
            end
        end
    end

    // S1: capture the walk result and the boards needed to build the post-move state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1          <= 1'b0;
            s1_flip     <= '0;
            s1_player   <= '0;
            s1_opponent <= '0;
            s1_pos_bit  <= '0;
            s1_apply    <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_flip     <= walk_flip;
                s1_player   <= player;
                s1_opponent <= opponent;
                s1_pos_bit  <= pos_bit;
                s1_apply    <= apply;
            end
        end
    end

    // Legality is just a non-empty flip set, since the walk is already gated on an empty in-range square.
    always_comb begin
        legal_c = |s1_flip;
        count_c = '0;
        for (int i = 0; i < CELLS; i++) begin
            count_c = count_c + CW'(s1_flip[i]);
        end
        if (legal_c && s1_apply) begin
            next_player_c   = s1_opponent & ~s1_flip;
            next_opponent_c = s1_player | s1_flip | s1_pos_bit;
        end else begin
            next_player_c   = s1_player;
            next_opponent_c = s1_opponent;
        end
    end

    // S2: result register driving the outputs directly, so they stay frozen while stalled.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v2            <= 1'b0;
            flip          <= '0;
            legal         <= 1'b0;
            count         <= '0;
            next_player   <= '0;
            next_opponent <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                flip          <= s1_flip;
                legal         <= legal_c;
                count         <= count_c;
                next_player   <= next_player_c;
                next_opponent <= next_opponent_c;
            end
        end
    end

endmodule
